// File: rtl/distribute_1to2_seq.sv
// 1-to-2 distribution node: steers each accepted word to lane 0, lane 1, both, or drops it,
// buffering each lane in its own small registered FIFO with valid/ready on every side.
module distribute_1to2_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_data_bus,
    input  logic [1:0]              i_cmd,
    output logic                    o_ready,
    output logic [1:0]              o_valid,
    output logic [2*DATA_WIDTH-1:0] o_data_bus,
    input  logic [1:0]              i_ready,
    input  logic                    i_en
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [1:0] pop;
    logic [1:0] push;
    logic [1:0] space;
    logic       accept;

    // A multicast word needs room in both lanes before anything is written, so that it is
    // never delivered to only one of them.
    assign o_ready = i_en & (~i_cmd[0] | space[0]) & (~i_cmd[1] | space[1]);
    assign accept  = i_valid & o_ready;

    for (genvar k = 0; k < 2; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
        logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]         cnt_q, cnt_d;
        logic                  nonempty;

        assign nonempty   = (cnt_q != '0);
        assign o_valid[k] = nonempty;
        assign pop[k]     = nonempty & i_ready[k];
        assign space[k]   = (cnt_q < DEPTH_C) | pop[k];
        assign push[k]    = accept & i_cmd[k];

        assign o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] =
            nonempty ? mem_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push[k]) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop[k]) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push[k], pop[k]})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage needs no reset: an empty lane never exposes it.
        always_ff @(posedge clk) begin
            if (push[k]) begin
                mem_q[wr_ptr_q] <= i_data_bus;
            end
        end
    end

endmodule

// File: tb/tb_distribute_1to2_seq.sv
// Directed bench for distribute_1to2_seq: per-lane scoreboard queues filled on accept and
// consumed when a lane pops; handshake outputs checked against a small occupancy model.
module tb_distribute_1to2_seq;

    localparam int DW    = 16;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic [DW-1:0] i_data_bus;
    logic [1:0]    i_cmd;
    logic          o_ready;
    logic [1:0]    o_valid;
    logic [2*DW-1:0] o_data_bus;
    logic [1:0]    i_ready;
    logic          i_en;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    distribute_1to2_seq #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_cmd      (i_cmd),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .i_ready    (i_ready),
        .i_en       (i_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven; checks outputs, then
    // advances one clock and updates the scoreboard with what the model says happened.
    task automatic step(output bit acc);
        bit [1:0]      ev;
        bit [1:0]      popm;
        bit [1:0]      sp;
        bit            er;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        #1;
        ev[0] = (q0.size() != 0);
        ev[1] = (q1.size() != 0);
        popm  = ev & i_ready;
        sp[0] = (q0.size() < DEPTH) || popm[0];
        sp[1] = (q1.size() < DEPTH) || popm[1];
        er    = i_en & (~i_cmd[0] | sp[0]) & (~i_cmd[1] | sp[1]);
        e0    = ev[0] ? q0[0] : '0;
        e1    = ev[1] ? q1[0] : '0;
        chk("o_ready", {31'b0, o_ready}, {31'b0, er});
        chk("o_valid", {30'b0, o_valid}, {30'b0, ev});
        chk("lane0_data", {16'b0, o_data_bus[DW-1:0]}, {16'b0, e0});
        chk("lane1_data", {16'b0, o_data_bus[2*DW-1:DW]}, {16'b0, e1});
        acc = i_valid & er;
        @(posedge clk);
        if (popm[0]) void'(q0.pop_front());
        if (popm[1]) void'(q1.pop_front());
        if (acc && i_cmd[0]) q0.push_back(i_data_bus);
        if (acc && i_cmd[1]) q1.push_back(i_data_bus);
        @(negedge clk);
    endtask

    task automatic cyc();
        bit a;
        step(a);
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [DW-1:0] d);
        i_valid    = v;
        i_cmd      = c;
        i_data_bus = d;
    endtask

    initial begin
        bit acc;
        int sent;
        rst_n   = 1'b0;
        i_en    = 1'b1;
        i_ready = 2'b00;
        drive(1'b0, 2'b00, '0);
        @(negedge clk);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reset mid-stream, then first word after release
        drive(1'b1, 2'b01, 16'h0001);
        cyc();
        drive(1'b1, 2'b11, 16'h0002);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_o_valid", {30'b0, o_valid}, 32'h0);
        chk("rst_o_data", o_data_bus, 32'h0);
        q0.delete();
        q1.delete();
        drive(1'b0, 2'b00, '0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'b01, 16'h00A5);
        cyc();
        drive(1'b0, 2'b00, '0);
        chk("a5_queued", q0.size(), 32'd1);
        cyc();
        i_ready = 2'b11;
        cyc();
        cyc();

        // Unicast alternating stream at full rate
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, (i % 2 == 1) ? 2'b01 : 2'b10, DW'(i));
            step(acc);
            chk("stream_accept", {31'b0, acc}, 32'd1);
        end
        drive(1'b0, 2'b00, '0);
        for (int i = 0; i < 3; i++) cyc();

        // Back-pressure on lane 0: third word waits, then enters as the first pops
        i_ready = 2'b00;
        drive(1'b1, 2'b01, 16'h0001);
        cyc();
        drive(1'b1, 2'b01, 16'h0002);
        cyc();
        drive(1'b1, 2'b01, 16'h0003);
        cyc();
        cyc();
        chk("full_lane0", q0.size(), 32'd2);
        i_ready = 2'b01;
        cyc();
        drive(1'b0, 2'b00, '0);
        for (int i = 0; i < 4; i++) cyc();

        // Multicast blocked by full lane 1, then delivered to both lanes together
        i_ready = 2'b00;
        drive(1'b1, 2'b10, 16'h0011);
        cyc();
        drive(1'b1, 2'b10, 16'h0022);
        cyc();
        drive(1'b1, 2'b11, 16'hBEEF);
        cyc();
        cyc();
        i_ready = 2'b10;
        cyc();
        drive(1'b0, 2'b00, '0);
        i_ready = 2'b00;
        cyc();
        i_ready = 2'b11;
        for (int i = 0; i < 4; i++) cyc();

        // Drop command and enable gating
        drive(1'b1, 2'b00, 16'h0055);
        cyc();
        i_ready = 2'b00;
        drive(1'b1, 2'b01, 16'h0066);
        cyc();
        i_en    = 1'b0;
        i_ready = 2'b01;
        drive(1'b1, 2'b01, 16'h0077);
        cyc();
        cyc();
        i_en = 1'b1;
        cyc();
        drive(1'b0, 2'b00, '0);
        for (int i = 0; i < 3; i++) cyc();

        // Wrap-around: 20 words with lane 0 ready toggling every cycle
        sent = 0;
        for (int c = 0; c < 200 && sent < 20; c++) begin
            drive(1'b1, 2'b01, DW'(16'h0100 + sent));
            i_ready = {1'b0, c[0]};
            step(acc);
            if (acc) sent++;
        end
        chk("wrap_sent", sent, 32'd20);
        drive(1'b0, 2'b00, '0);
        i_ready = 2'b11;
        for (int c = 0; c < 20 && q0.size() != 0; c++) cyc();
        cyc();
        chk("wrap_drained", q0.size() + q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
